// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared constants for the USB transmit scheduler:
//   - decoded RX PID codes as delivered by the RX packet decoder
//   - request codes driven to the TX FSM on tx_packet
//   - scheduler state encoding and a helper mapping a state to its TX request
// ---------------------------------------------------------------------------
package usb_pkg;

   // Decoded RX PID codes (rx_packet)
   localparam logic [2:0] PID_NONE = 3'd0;
   localparam logic [2:0] PID_OUT  = 3'd1;
   localparam logic [2:0] PID_IN   = 3'd2;
   localparam logic [2:0] PID_DATA = 3'd3;
   localparam logic [2:0] PID_ACK  = 3'd4;
   localparam logic [2:0] PID_NAK  = 3'd5;
   localparam logic [2:0] PID_BAD  = 3'd6;

   // Requests to the TX FSM (tx_packet)
   localparam logic [1:0] TX_IDLE = 2'd0;
   localparam logic [1:0] TX_DATA = 2'd1;
   localparam logic [1:0] TX_ACK  = 2'd2;
   localparam logic [1:0] TX_NAK  = 2'd3;

   // Scheduler states; explicit encodings keep the state register stable
   // across tool versions and easy to read in waveforms.
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_ODATA = 3'd1,
      ST_SEND_ACK   = 3'd2,
      ST_SEND_NAK   = 3'd3,
      ST_SEND_DATA  = 3'd4,
      ST_WAIT_HS    = 3'd5
   } sched_state_t;

   // TX request associated with a state; non-transmitting states request idle.
   function automatic logic [1:0] tx_code_for_state(input sched_state_t st);
      logic [1:0] code;
      case (st)
         ST_SEND_ACK:  code = TX_ACK;
         ST_SEND_NAK:  code = TX_NAK;
         ST_SEND_DATA: code = TX_DATA;
         default:      code = TX_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/turnaround_timer.sv
// ---------------------------------------------------------------------------
// turnaround_timer
// Bus-turnaround counter used while the scheduler waits for the host.
// Ports:
//   clk, n_rst   : clock, asynchronous active-low reset
//   clear        : synchronous clear (takes priority over enable)
//   enable       : count one per cycle; holds at all-ones instead of wrapping
//   rollover     : high while the count equals HS_TIMEOUT-1
// ---------------------------------------------------------------------------
module turnaround_timer #(
   parameter int HS_TIMEOUT = 1024,
   parameter int TMR_W      = 11
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic rollover
);

   logic [TMR_W-1:0] count_q;
   logic [TMR_W-1:0] count_d;

   // Next count: clear wins, then increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != {TMR_W{1'b1}})) begin
         count_d = count_q + TMR_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign rollover = (count_q == TMR_W'(HS_TIMEOUT - 1));

endmodule

// File: rtl/usb_tx_scheduler.sv
// ---------------------------------------------------------------------------
// usb_tx_scheduler
// Decides which packet the USB TX FSM sends and when: answers IN tokens with
// DATA or NAK, answers host OUT data with ACK or NAK, and times the host
// handshake after device DATA, reporting completion or error.
// Ports:
//   clk, n_rst           : clock, asynchronous active-low reset
//   rx_packet/_valid     : decoded RX PID with one-cycle strobe
//   rx_error             : RX packet just ended with an error (level)
//   tx_data_pending      : AHB side has a payload staged
//   tx_size              : staged payload size (bytes)
//   buffer_occupancy     : bytes currently buffered
//   tx_done              : TX FSM finished the current packet (pulse)
//   tx_packet            : request to the TX FSM (idle/DATA/ACK/NAK)
//   tx_packet_data_size  : payload size latched when DATA is scheduled
//   tx_transfer_active   : device DATA transfer in progress
//   tx_complete          : pulse, host ACKed device DATA
//   tx_error             : pulse, handshake failed or timed out
//   rx_ack_sent          : pulse, ACK for host OUT data went out
// All outputs are registered.
// ---------------------------------------------------------------------------
module usb_tx_scheduler #(
   parameter int HS_TIMEOUT = 1024,
   parameter int TMR_W      = 11
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] rx_packet,
   input  logic       rx_packet_valid,
   input  logic       rx_error,
   input  logic       tx_data_pending,
   input  logic [6:0] tx_size,
   input  logic [6:0] buffer_occupancy,
   input  logic       tx_done,
   output logic [1:0] tx_packet,
   output logic [6:0] tx_packet_data_size,
   output logic       tx_transfer_active,
   output logic       tx_complete,
   output logic       tx_error,
   output logic       rx_ack_sent
);

   import usb_pkg::*;

   sched_state_t state_q, state_d;
   logic [1:0]   tx_packet_q, tx_packet_d;
   logic [6:0]   data_size_q, data_size_d;
   logic         active_q, active_d;
   logic         complete_q, complete_d;
   logic         error_q, error_d;
   logic         ack_sent_q, ack_sent_d;

   logic         tmr_clear;
   logic         tmr_enable;
   logic         tmr_rollover;

   // Next-state and pulse logic. A valid packet is checked before the
   // timeout so that a packet arriving on the timeout cycle wins.
   always_comb begin
      state_d     = state_q;
      data_size_d = data_size_q;
      complete_d  = 1'b0;
      error_d     = 1'b0;
      ack_sent_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_packet_valid && !rx_error) begin
               if (rx_packet == PID_IN) begin
                  if (tx_data_pending && (buffer_occupancy >= tx_size)) begin
                     state_d     = ST_SEND_DATA;
                     data_size_d = tx_size;
                  end else begin
                     state_d = ST_SEND_NAK;
                  end
               end else if (rx_packet == PID_OUT) begin
                  state_d = ST_WAIT_ODATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_ODATA: begin
            if (rx_packet_valid) begin
               if (rx_packet == PID_DATA) begin
                  state_d = rx_error ? ST_SEND_NAK : ST_SEND_ACK;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (tmr_rollover) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_ODATA;
            end
         end
         ST_SEND_ACK: begin
            if (tx_done) begin
               state_d    = ST_IDLE;
               ack_sent_d = 1'b1;
            end else begin
               state_d = ST_SEND_ACK;
            end
         end
         ST_SEND_NAK: begin
            if (tx_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SEND_NAK;
            end
         end
         ST_SEND_DATA: begin
            if (tx_done) begin
               state_d = ST_WAIT_HS;
            end else begin
               state_d = ST_SEND_DATA;
            end
         end
         ST_WAIT_HS: begin
            if (rx_packet_valid) begin
               state_d = ST_IDLE;
               if ((rx_packet == PID_ACK) && !rx_error) begin
                  complete_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end else if (tmr_rollover) begin
               state_d = ST_IDLE;
               error_d = 1'b1;
            end else begin
               state_d = ST_WAIT_HS;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output request and transfer flag. The request follows the current
   // state, so it appears the cycle after entering a SEND state and drops
   // the cycle after tx_done, preventing a retrigger of the TX FSM.
   always_comb begin
      if (tx_done) begin
         tx_packet_d = TX_IDLE;
      end else begin
         tx_packet_d = tx_code_for_state(state_q);
      end
      active_d = (state_d == ST_SEND_DATA) || (state_d == ST_WAIT_HS);
   end

   // Timer control: cleared on any state change, counts only while waiting.
   always_comb begin
      tmr_clear  = (state_d != state_q);
      tmr_enable = (state_q == ST_WAIT_ODATA) || (state_q == ST_WAIT_HS);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         tx_packet_q <= TX_IDLE;
         data_size_q <= 7'd0;
         active_q    <= 1'b0;
         complete_q  <= 1'b0;
         error_q     <= 1'b0;
         ack_sent_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_packet_q <= tx_packet_d;
         data_size_q <= data_size_d;
         active_q    <= active_d;
         complete_q  <= complete_d;
         error_q     <= error_d;
         ack_sent_q  <= ack_sent_d;
      end
   end

   turnaround_timer #(
      .HS_TIMEOUT (HS_TIMEOUT),
      .TMR_W      (TMR_W)
   ) u_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (tmr_clear),
      .enable   (tmr_enable),
      .rollover (tmr_rollover)
   );

   assign tx_packet           = tx_packet_q;
   assign tx_packet_data_size = data_size_q;
   assign tx_transfer_active  = active_q;
   assign tx_complete         = complete_q;
   assign tx_error            = error_q;
   assign rx_ack_sent         = ack_sent_q;

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
Protocol-level controller that decides which packet the USB transmit FSM sends, and when it sends it. It sits between the RX packet decoder, the AHB-side data staging logic and the TX FSM. It answers IN tokens with DATA or NAK and answers received OUT data with ACK or NAK. It also times the host handshake after device DATA and reports completion or error to the AHB slave.

Parameters:
HS_TIMEOUT, 1024, cycles to wait for a host handshake after device DATA, or for host DATA after an OUT token.
TMR_W, 11, timer width; must satisfy 2^TMR_W > HS_TIMEOUT.

Ports:
clk  in  1  system clock
n_rst  in  1  reset
rx_packet  in  3  decoded RX PID: 000 none, 001 OUT, 010 IN, 011 DATA, 100 ACK, 101 NAK, 110 other/bad
rx_packet_valid  in  1  one-cycle strobe; rx_packet is valid this cycle
rx_error  in  1  level; the RX packet that just ended had a CRC/stuff/EOP error
tx_data_pending  in  1  level from AHB side; a transmit payload is staged
tx_size  in  7  staged payload size in bytes, 1..64
buffer_occupancy  in  7  bytes currently in the data buffer
tx_done  in  1  one-cycle pulse from the TX FSM at end of EOP
tx_packet  out  2  00 idle, 01 DATA, 10 ACK, 11 NAK; request to the TX FSM
tx_packet_data_size  out  7  payload size for a DATA request
tx_transfer_active  out  1  high from DATA request until the handshake resolves
tx_complete  out  1  one-cycle pulse; host ACKed device DATA
tx_error  out  1  one-cycle pulse; host NAK, bad PID or timeout after device DATA
rx_ack_sent  out  1  one-cycle pulse; ACK for host OUT data finished transmitting

Behaviour:
- Clock and reset: one clock, clk; reset n_rst is asynchronous, active-low.
- Reset: state IDLE, timer 0, and every output 0.
- All outputs are registered.
- States:
  - IDLE
  - WAIT_ODATA: OUT seen, awaiting host DATA
  - SEND_ACK
  - SEND_NAK
  - SEND_DATA
  - WAIT_HS: device DATA sent, awaiting host handshake
- IDLE transitions:
  - valid IN with tx_data_pending=1 and buffer_occupancy >= tx_size -> SEND_DATA. tx_packet_data_size latches tx_size.
  - valid IN otherwise -> SEND_NAK.
  - valid OUT -> WAIT_ODATA, timer cleared.
  - Any other PID, or rx_error -> stay in IDLE.
- WAIT_ODATA transitions:
  - valid DATA with rx_error=0 -> SEND_ACK.
  - valid DATA with rx_error=1 -> SEND_NAK.
  - any other valid PID -> IDLE.
  - timer reaches HS_TIMEOUT-1 -> IDLE. The exit happens exactly HS_TIMEOUT cycles after entry.
- SEND_ACK, SEND_NAK, SEND_DATA:
  - tx_packet drives 10, 11 or 01 starting the cycle after entry.
  - tx_packet is held stable until tx_done is sampled.
  - tx_packet returns to 00 the cycle after tx_done, so the TX FSM never retriggers.
  - On tx_done: SEND_ACK -> IDLE with an rx_ack_sent pulse. SEND_NAK -> IDLE. SEND_DATA -> WAIT_HS, timer cleared.
- WAIT_HS transitions:
  - valid ACK (rx_error=0) -> IDLE with a tx_complete pulse.
  - valid NAK, any other valid PID, any valid PID with rx_error=1, or timeout at HS_TIMEOUT-1 -> IDLE with a tx_error pulse.
  - tx_transfer_active is high from SEND_DATA entry through the WAIT_HS exit cycle, and low the cycle after.
- Ignored inputs:
  - rx_packet_valid is ignored in all SEND_* states, because the bus is owned by the device.
  - tx_done is ignored outside SEND_* states.
  - Deassertion of tx_data_pending during SEND_DATA or WAIT_HS is ignored; the transfer completes.
  - tx_size changes after the latch have no effect.
- Timer: counts only in WAIT_ODATA and WAIT_HS, is cleared on every state change, and saturates (it does not wrap).
- Boundary case: if a valid packet and the timeout coincide in the same cycle, the packet wins.
- Reset mid-operation: immediate return to IDLE with all outputs 0. An in-flight tx_packet is dropped.

Decomposition:
- Package usb_pkg holds:
  - rx PID codes (3-bit localparams)
  - tx_packet codes (TX_IDLE=2'd0, TX_DATA=2'd1, TX_ACK=2'd2, TX_NAK=2'd3)
  - scheduler state enum
- Sub-module turnaround_timer:
  - counter with clear, enable and saturate
  - rollover flag at HS_TIMEOUT-1
  - parameterised on TMR_W

Test Plan:
1. Payload ready: tx_data_pending=1, tx_size=8, occupancy=8, IN strobe -> tx_packet=01 and size=8 held until tx_done. Host ACK 20 cycles later -> tx_complete pulse, tx_transfer_active falls the next cycle.
2. Short buffer: tx_size=16, occupancy=15, IN -> tx_packet=11. After tx_done: IDLE, tx_transfer_active never high.
3. Host OUT data: OUT strobe, then DATA with rx_error=0 -> tx_packet=10, rx_ack_sent pulse after tx_done. Repeat with rx_error=1 -> tx_packet=11, no rx_ack_sent.
4. Timeout boundary: after device DATA, no handshake -> tx_error exactly HS_TIMEOUT cycles after WAIT_HS entry. A host ACK arriving on the timeout cycle -> tx_complete, no tx_error.
5. Host NAK: NAK in WAIT_HS -> tx_error pulse. With tx_data_pending still 1, a second IN -> DATA is resent.
6. Reset mid-SEND_DATA: n_rst low while tx_packet=01 -> all outputs 0 asynchronously. After release, an IN is handled normally.
